// File: rtl/reg_stack_pkg.sv
// Shared op encodings and width helper for the operand stack.
package reg_stack_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Count must represent 0..depth inclusive.
  function automatic int unsigned calc_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_word.sv
// One stack entry: WIDTH-bit register with write enable and async active-low clear.
module reg_word #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture i_d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_stack.sv
// Operand stack with push/pop/replace, combinational TOS/NOS, full/empty and sticky errors.
module reg_stack
  import reg_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  // Derived from DEPTH; leave at its default.
  parameter int unsigned CW    = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic [1:0]       w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic [CW-1:0]    w_wr_idx;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [DEPTH-1:0] w_we;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] w_tos;
  logic [WIDTH-1:0] w_nos;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Decode the op into a single write, the next count and error-set pulses.
  always_comb begin
    w_op      = {push, pop};
    w_wr_en   = 1'b0;
    w_wr_idx  = r_count;
    w_cnt_nxt = r_count;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      OP_HOLD: ;
      OP_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_count + CW'(1);
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_cnt_nxt = r_count - CW'(1);
        end
      end
      OP_REPL: begin
        // Replace on an empty stack degenerates to a push into entry 0.
        w_wr_en = 1'b1;
        if (w_empty) begin
          w_cnt_nxt = CW'(1);
        end else begin
          w_wr_idx = r_count - CW'(1);
        end
      end
    endcase
  end

  // Storage: one-hot write enable per entry.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_we[g] = w_wr_en && (w_wr_idx == CW'(g));

    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .rst_n (reset),
      .i_we  (w_we[g]),
      .i_d   (din),
      .o_q   (w_q[g])
    );
  end

  // Count register; saturation is handled by the decode above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_cnt_nxt;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
      r_underflow <= w_unf_set | (r_underflow & ~clr_err);
    end
  end

  // TOS/NOS read muxes keyed on count; zero when the entry does not exist.
  always_comb begin
    w_tos = '0;
    w_nos = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_count == CW'(i + 1)) w_tos = w_q[i];
    end
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (r_count == CW'(i + 2)) w_nos = w_q[i];
    end
  end

  assign tos       = w_tos;
  assign nos       = w_nos;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
